// File: rtl/plot_sink_pkg.sv
// -----------------------------------------------------------------------------
// plot_sink_pkg
// Shared display package used by the sprite drawers and the plot sink.
// Holds the screen geometry, the colour and framebuffer address widths, the
// FIFO entry layout and a helper that turns (x, y) into a linear address.
// No ports: constants, types and functions only.
// -----------------------------------------------------------------------------
package plot_sink_pkg;

  localparam int X_SCREEN_PIXELS = 160;
  localparam int Y_SCREEN_PIXELS = 120;

  localparam int COLOUR_W = 9;
  localparam int ADDR_W   = 15;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int CNT_W    = 16;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef struct packed {
    addr_t   addr;
    colour_t colour;
  } plot_entry_t;

  localparam int ENTRY_W = $bits(plot_entry_t);

  // The multiply is carried out at the full address width, so the largest
  // on-screen address (119*160+159 = 19199) fits without truncation.
  function automatic addr_t pixel_addr(input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y,
                                       input int             x_pixels);
    return ADDR_W'(y) * ADDR_W'(x_pixels) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/plot_sink_if.sv
// -----------------------------------------------------------------------------
// plot_sink_if
// Bundles the pixel-beat handshake, the flush handshake, the framebuffer
// write port and the statistics counters of plot_sink.
//   master : the pixel producer / framebuffer side (drives iX, iY, iColour,
//            iPlot, iFlush, iMemGnt; observes everything else)
//   slave  : plot_sink itself
// -----------------------------------------------------------------------------
interface plot_sink_if;
  import plot_sink_pkg::*;

  logic [X_W-1:0]      iX;
  logic [Y_W-1:0]      iY;
  logic [COLOUR_W-1:0] iColour;
  logic                iPlot;
  logic                oReady;
  logic                iFlush;
  logic                oFlushed;
  logic [ADDR_W-1:0]   oMemAddr;
  logic [COLOUR_W-1:0] oMemData;
  logic                oMemWe;
  logic                iMemGnt;
  logic [CNT_W-1:0]    oWrCnt;
  logic [CNT_W-1:0]    oDropCnt;

  modport master (
    output iX, iY, iColour, iPlot, iFlush, iMemGnt,
    input  oReady, oFlushed, oMemAddr, oMemData, oMemWe, oWrCnt, oDropCnt
  );

  modport slave (
    input  iX, iY, iColour, iPlot, iFlush, iMemGnt,
    output oReady, oFlushed, oMemAddr, oMemData, oMemWe, oWrCnt, oDropCnt
  );

endinterface

// File: rtl/plot_fifo.sv
// -----------------------------------------------------------------------------
// plot_fifo
// Small synchronous FIFO holding pending framebuffer writes.
//   clk, rst   : clock and synchronous active-high reset (empties the FIFO)
//   push       : enqueue push_data (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   head       : current head entry, valid while !empty
//   count      : number of stored entries
//   full/empty : status flags derived from count
// A push while full is dropped rather than passed through, so the producer
// must see a pop complete before it can refill the last slot.
// -----------------------------------------------------------------------------
module plot_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 24,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end

    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plot_sink.sv
// -----------------------------------------------------------------------------
// plot_sink
// Accepts pixel beats (x, y, colour), filters off-screen and transparent
// pixels, buffers the rest as {address, colour} and issues them as
// framebuffer writes under a write/grant handshake. A flush request drains
// every pending write and reports completion with a one-cycle pulse.
//   iClock : single clock, all state changes on its rising edge
//   iReset : synchronous active-high reset, overrides every other input
//   bus    : plot_sink_if.slave carrying the beat handshake (iX, iY, iColour,
//            iPlot, oReady), the flush handshake (iFlush, oFlushed), the
//            framebuffer port (oMemAddr, oMemData, oMemWe, iMemGnt) and the
//            write / drop counters (oWrCnt, oDropCnt)
// -----------------------------------------------------------------------------
module plot_sink #(
  parameter int X_SCREEN_PIXELS = plot_sink_pkg::X_SCREEN_PIXELS,
  parameter int Y_SCREEN_PIXELS = plot_sink_pkg::Y_SCREEN_PIXELS,
  parameter int FIFO_DEPTH      = 4,
  parameter bit TRANSPARENT_EN  = 1'b1
) (
  input  logic        iClock,
  input  logic        iReset,
  plot_sink_if.slave  bus
);

  import plot_sink_pkg::*;

  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

  // IDLE : FIFO empty, accepting beats
  // BUSY : writes pending, accepting beats
  // DRAIN: flushing, no new beats accepted
  // DONE : flush complete, one-cycle oFlushed pulse
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic                  ready;
  logic                  accept;
  logic                  in_range;
  logic                  transparent;
  logic                  do_push;
  logic                  do_drop;
  logic                  do_pop;
  logic                  last_pop;
  plot_entry_t           push_entry;
  plot_entry_t           head;
  logic [ENTRY_W-1:0]    head_bits;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Beat classification: a beat is accepted whenever it is offered while
  // ready, and then either queued or counted as dropped.
  always_comb begin
    ready       = ((state_q == IDLE) || (state_q == BUSY)) && !fifo_full;
    accept      = bus.iPlot && ready;
    in_range    = (int'(bus.iX) < X_SCREEN_PIXELS) &&
                  (int'(bus.iY) < Y_SCREEN_PIXELS);
    transparent = TRANSPARENT_EN && (bus.iColour == '0);
    do_push     = accept && in_range && !transparent;
    do_drop     = accept && !do_push;
    do_pop      = !fifo_empty && bus.iMemGnt;
    last_pop    = do_pop && !do_push && (fifo_count == FIFO_CNT_W'(1));
    push_entry  = '{addr:   pixel_addr(bus.iX, bus.iY, X_SCREEN_PIXELS),
                    colour: bus.iColour};
  end

  plot_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (iClock),
    .rst       (iReset),
    .push      (do_push),
    .push_data (push_entry),
    .pop       (do_pop),
    .head      (head_bits),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head = plot_entry_t'(head_bits);

  // Next-state logic. A flush raised together with a beat still takes the
  // beat, because the push happens in the same cycle as the transition into
  // DRAIN. A flush of an already-empty FIFO spends one cycle in DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iFlush)   state_d = DRAIN;
        else if (do_push) state_d = BUSY;
      end
      BUSY: begin
        if (bus.iFlush)    state_d = DRAIN;
        else if (last_pop) state_d = IDLE;
      end
      DRAIN: begin
        if (fifo_empty || last_pop) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters wrap naturally at 16 bits.
  always_comb begin
    wr_cnt_d   = wr_cnt_q + CNT_W'(do_pop);
    drop_cnt_d = drop_cnt_q + CNT_W'(do_drop);
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Address and data are forced to zero while nothing is pending so the
  // framebuffer port is quiet after reset.
  assign bus.oReady   = ready;
  assign bus.oFlushed = (state_q == DONE);
  assign bus.oMemWe   = !fifo_empty;
  assign bus.oMemAddr = fifo_empty ? '0 : head.addr;
  assign bus.oMemData = fifo_empty ? '0 : head.colour;
  assign bus.oWrCnt   = wr_cnt_q;
  assign bus.oDropCnt = drop_cnt_q;

endmodule

// File: tb/tb_plot_sink.sv
// -----------------------------------------------------------------------------
// tb_plot_sink
// Self-checking bench for plot_sink: a vector table drives single beats,
// a scoreboard queue holds the framebuffer writes each accepted beat should
// produce, and hand-written sequences cover backpressure, flush and reset.
// -----------------------------------------------------------------------------
module tb_plot_sink;
  import plot_sink_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  plot_sink_if bus();

  plot_sink #(
    .X_SCREEN_PIXELS (160),
    .Y_SCREEN_PIXELS (120),
    .FIFO_DEPTH      (4),
    .TRANSPARENT_EN  (1'b1)
  ) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [8:0]  col;
    bit          drop;
    logic [14:0] addr;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [8:0]  data;
  } wr_t;

  vec_t vecs[10];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   expWr = 0;
  int   expDrop = 0;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offers one beat starting just after a rising edge, checks oReady against
  // what the bench expects, and records the expected outcome. Returns one
  // time unit after the edge that sampled the beat.
  task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y,
                               input logic [8:0] col, input bit expReady,
                               input bit expDropFlag, input logic [14:0] expAddr);
    wr_t w;
    bus.iX      = x;
    bus.iY      = y;
    bus.iColour = col;
    bus.iPlot   = 1'b1;
    @(negedge clk);
    checkOutput("ready", 32'(bus.oReady), 32'(expReady));
    if (expReady) begin
      if (expDropFlag) begin
        expDrop++;
      end else begin
        w.addr = expAddr;
        w.data = col;
        sb.push_back(w);
        expWr++;
      end
    end
    @(posedge clk);
    #1;
    bus.iPlot = 1'b0;
  endtask

  // Waits, with a cycle bound, for every expected write to be observed.
  task automatic waitDrain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor: every granted write must match the oldest expected
  // entry, and no write may appear when nothing is expected.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && bus.oMemWe && bus.iMemGnt) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0d data %0d, expected no write",
                 bus.oMemAddr, bus.oMemData);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.oMemAddr), 32'(e.addr));
        checkOutput("wr_data", 32'(bus.oMemData), 32'(e.data));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  // Main test sequence.
  initial begin
    bit seen;

    vecs[0] = '{8'd5,   7'd3,   9'h1FF, 1'b0, 15'd485};
    vecs[1] = '{8'd160, 7'd0,   9'h001, 1'b1, 15'd0};
    vecs[2] = '{8'd0,   7'd120, 9'h001, 1'b1, 15'd0};
    vecs[3] = '{8'd10,  7'd10,  9'h000, 1'b1, 15'd0};
    vecs[4] = '{8'd159, 7'd119, 9'h007, 1'b0, 15'd19199};
    vecs[5] = '{8'd0,   7'd0,   9'h001, 1'b0, 15'd0};
    vecs[6] = '{8'd255, 7'd127, 9'h1FF, 1'b1, 15'd0};
    vecs[7] = '{8'd159, 7'd0,   9'h100, 1'b0, 15'd159};
    vecs[8] = '{8'd0,   7'd119, 9'h001, 1'b0, 15'd19040};
    vecs[9] = '{8'd100, 7'd50,  9'h0AA, 1'b0, 15'd8100};

    bus.iX      = '0;
    bus.iY      = '0;
    bus.iColour = '0;
    bus.iPlot   = 1'b0;
    bus.iFlush  = 1'b0;
    bus.iMemGnt = 1'b0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_ready",   32'(bus.oReady),   32'd1);
    checkOutput("rst_we",      32'(bus.oMemWe),   32'd0);
    checkOutput("rst_addr",    32'(bus.oMemAddr), 32'd0);
    checkOutput("rst_data",    32'(bus.oMemData), 32'd0);
    checkOutput("rst_flushed", 32'(bus.oFlushed), 32'd0);
    checkOutput("rst_wrcnt",   32'(bus.oWrCnt),   32'd0);
    checkOutput("rst_dropcnt", 32'(bus.oDropCnt), 32'd0);
    @(posedge clk);
    #1;

    // One-cycle latency from acceptance to oMemWe, head held until granted
    $display("[TB] latency sequence");
    bus.iX      = 8'd5;
    bus.iY      = 7'd3;
    bus.iColour = 9'h1FF;
    bus.iPlot   = 1'b1;
    sb.push_back('{15'd485, 9'h1FF});
    expWr++;
    @(negedge clk);
    checkOutput("lat_we_before", 32'(bus.oMemWe), 32'd0);
    @(posedge clk);
    #1 bus.iPlot = 1'b0;
    @(negedge clk);
    checkOutput("lat_we",   32'(bus.oMemWe),   32'd1);
    checkOutput("lat_addr", 32'(bus.oMemAddr), 32'd485);
    checkOutput("lat_data", 32'(bus.oMemData), 32'h1FF);
    @(posedge clk);
    #1 bus.iMemGnt = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("lat_wrcnt", 32'(bus.oWrCnt), 32'd1);
    checkOutput("lat_we_after", 32'(bus.oMemWe), 32'd0);
    @(posedge clk);
    #1;

    // Vector table with the grant held high
    $display("[TB] vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].x, vecs[i].y, vecs[i].col, 1'b1, vecs[i].drop, vecs[i].addr);
      if (i == 3) checkOutput("drop_cnt_3", 32'(bus.oDropCnt), 32'(expDrop));
    end
    waitDrain();
    checkOutput("table_wrcnt",   32'(bus.oWrCnt),   32'(expWr));
    checkOutput("table_dropcnt", 32'(bus.oDropCnt), 32'(expDrop));

    // Backpressure: four beats fill the FIFO, the fifth sees oReady low
    $display("[TB] backpressure sequence");
    bus.iMemGnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(20 + i), 7'd2, 9'(i + 1), (i < 4), 1'b0, 15'(2 * 160 + 20 + i));
    end
    checkOutput("bp_pending", 32'(sb.size()), 32'd4);
    bus.iMemGnt = 1'b1;
    waitDrain();
    checkOutput("bp_wrcnt", 32'(bus.oWrCnt), 32'(expWr));

    // Flush with two entries pending
    $display("[TB] flush sequence");
    bus.iMemGnt = 1'b0;
    applyStimulus(8'd1, 7'd1, 9'h011, 1'b1, 1'b0, 15'd161);
    applyStimulus(8'd2, 7'd1, 9'h022, 1'b1, 1'b0, 15'd162);
    bus.iFlush  = 1'b1;
    bus.iMemGnt = 1'b1;
    @(posedge clk);
    #1 bus.iFlush = 1'b0;
    @(negedge clk);
    checkOutput("fl_ready_drain", 32'(bus.oReady),   32'd0);
    checkOutput("fl_flushed_early", 32'(bus.oFlushed), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("fl_flushed",  32'(bus.oFlushed), 32'd1);
    checkOutput("fl_ready_done", 32'(bus.oReady), 32'd0);
    checkOutput("fl_pending",  32'(sb.size()),    32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("fl_flushed_end", 32'(bus.oFlushed), 32'd0);
    checkOutput("fl_ready_idle",  32'(bus.oReady),   32'd1);
    checkOutput("fl_wrcnt",       32'(bus.oWrCnt),   32'(expWr));
    @(posedge clk);
    #1;

    // Beat and flush together: the beat is included in the drain
    $display("[TB] plot with flush sequence");
    bus.iMemGnt = 1'b0;
    bus.iFlush  = 1'b1;
    applyStimulus(8'd7, 7'd7, 9'h0F0, 1'b1, 1'b0, 15'd1127);
    bus.iFlush  = 1'b0;
    @(negedge clk);
    checkOutput("pf_ready_drain", 32'(bus.oReady), 32'd0);
    checkOutput("pf_we",          32'(bus.oMemWe), 32'd1);
    @(posedge clk);
    #1 bus.iMemGnt = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.oFlushed) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("pf_flushed_seen", 32'(seen), 32'd1);
    checkOutput("pf_pending",      32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;

    // Reset mid-operation discards pending writes
    $display("[TB] mid-operation reset sequence");
    bus.iMemGnt = 1'b0;
    applyStimulus(8'd30, 7'd5, 9'h003, 1'b1, 1'b0, 15'd830);
    applyStimulus(8'd31, 7'd5, 9'h004, 1'b1, 1'b0, 15'd831);
    applyStimulus(8'd32, 7'd5, 9'h005, 1'b1, 1'b0, 15'd832);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    expWr   = 0;
    expDrop = 0;
    @(negedge clk);
    checkOutput("mr_we",      32'(bus.oMemWe),   32'd0);
    checkOutput("mr_wrcnt",   32'(bus.oWrCnt),   32'd0);
    checkOutput("mr_dropcnt", 32'(bus.oDropCnt), 32'd0);
    checkOutput("mr_ready",   32'(bus.oReady),   32'd1);
    @(posedge clk);
    #1 bus.iMemGnt = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("mr_wrcnt_after", 32'(bus.oWrCnt), 32'(expWr));
    checkOutput("mr_we_after",    32'(bus.oMemWe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
